// File: rtl/lsu_pipe_if.sv
`default_nettype none
// ============================================================================
// Module      : lsu_pipe_if
// Description : Signal bundle for lsu_pipe. Carries the core-side request,
//               the req/gnt/rvalid data bus, writeback and exception outputs.
//               'master' is the load/store unit's view; 'slave' is the view
//               of the surrounding core and memory.
// Revision    : 1.0 - initial release
// ============================================================================
interface lsu_pipe_if #(
    parameter int ADDR_W = 32
);
    // Core-side request
    logic              req_valid_i;
    logic              req_ready_o;
    logic [6:0]        opcode_i;
    logic [2:0]        funct3_i;
    logic [4:0]        rd_i;
    logic [ADDR_W-1:0] addr_i;
    logic [31:0]       wdata_i;
    // Data bus
    logic              data_req_o;
    logic              data_gnt_i;
    logic [ADDR_W-1:0] data_addr_o;
    logic              data_we_o;
    logic [3:0]        data_be_o;
    logic [31:0]       data_wdata_o;
    logic              data_rvalid_i;
    logic [31:0]       data_rdata_i;
    // Writeback and status
    logic              wb_valid_o;
    logic [4:0]        wb_rd_o;
    logic [31:0]       wb_data_o;
    logic              misaligned_o;
    logic              illegal_o;
    logic [ADDR_W-1:0] exc_addr_o;
    logic              busy_o;

    modport master (
        input  req_valid_i, opcode_i, funct3_i, rd_i, addr_i, wdata_i,
               data_gnt_i, data_rvalid_i, data_rdata_i,
        output req_ready_o, data_req_o, data_addr_o, data_we_o, data_be_o,
               data_wdata_o, wb_valid_o, wb_rd_o, wb_data_o, misaligned_o,
               illegal_o, exc_addr_o, busy_o
    );

    modport slave (
        output req_valid_i, opcode_i, funct3_i, rd_i, addr_i, wdata_i,
               data_gnt_i, data_rvalid_i, data_rdata_i,
        input  req_ready_o, data_req_o, data_addr_o, data_we_o, data_be_o,
               data_wdata_o, wb_valid_o, wb_rd_o, wb_data_o, misaligned_o,
               illegal_o, exc_addr_o, busy_o
    );
endinterface
`default_nettype wire

// File: rtl/lsu_pipe.sv
`default_nettype none
// ============================================================================
// Module      : lsu_pipe
// Description : Pipelined load/store unit. Accepts one memory operation per
//               handshake, issues it on a req/gnt/rvalid bus through a single
//               hold register, tracks up to DEPTH outstanding transactions in
//               an in-order metadata FIFO and extends returning load data.
//               Misaligned and illegal operations are flagged, never issued.
// Revision    : 1.0 - initial release
// ============================================================================
module lsu_pipe #(
    parameter int ADDR_W = 32,
    parameter int DEPTH  = 2
) (
    input wire          clk,
    input wire          rst_n,
    lsu_pipe_if.master  bus
);

    localparam int         c_cnt_w   = $clog2(DEPTH) + 1;
    localparam int         c_ptr_w   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [6:0] c_op_load = 7'b0000011;
    localparam logic [6:0] c_op_store = 7'b0100011;

    // One FIFO entry describes how to treat the response of one bus transaction
    typedef struct packed {
        logic       is_load;
        logic [4:0] rd;
        logic [2:0] funct3;
        logic [1:0] off;
    } meta_t;

    // Hold register (drives the bus)
    logic              r_hold_valid;
    logic [ADDR_W-1:0] r_hold_addr;
    logic              r_hold_we;
    logic [3:0]        r_hold_be;
    logic [31:0]       r_hold_wdata;

    // Outstanding tracking
    logic [c_cnt_w-1:0] r_cnt;
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_rd_ptr;
    meta_t              r_meta [DEPTH];

    // Registered outputs
    logic              r_wb_valid;
    logic [4:0]        r_wb_rd;
    logic [31:0]       r_wb_data;
    logic              r_misaligned;
    logic              r_illegal;
    logic [ADDR_W-1:0] r_exc_addr;

    // Combinational decode
    logic        w_is_load;
    logic        w_is_store;
    logic        w_legal;
    logic        w_misaligned;
    logic [3:0]  w_be;
    logic [31:0] w_wdata;
    logic        w_ready;
    logic        w_accept;
    logic        w_issue;
    logic        w_pop;
    meta_t       w_head;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_load_data;

    function automatic logic [c_ptr_w-1:0] ptr_inc(input logic [c_ptr_w-1:0] p);
        return (p == c_ptr_w'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // A new operation can enter when there is a free slot and the hold is free or leaving
    assign w_ready  = (r_cnt < c_cnt_w'(DEPTH)) && (!r_hold_valid || bus.data_gnt_i);
    assign w_accept = bus.req_valid_i && w_ready;
    assign w_issue  = w_accept && w_legal && !w_misaligned;
    assign w_pop    = bus.data_rvalid_i && (r_cnt != '0);

    // Decode legality, alignment, byte enables and lane-replicated write data
    always_comb begin
        w_is_load    = (bus.opcode_i == c_op_load);
        w_is_store   = (bus.opcode_i == c_op_store);
        w_legal      = 1'b0;
        w_misaligned = 1'b0;
        w_be         = 4'b1111;
        w_wdata      = bus.wdata_i;
        case (bus.funct3_i)
            3'b000, 3'b001, 3'b010: w_legal = w_is_load || w_is_store;
            3'b100, 3'b101:         w_legal = w_is_load;
            default:                w_legal = 1'b0;
        endcase
        case (bus.funct3_i[1:0])
            2'b01:   w_misaligned = bus.addr_i[0];
            2'b10:   w_misaligned = (bus.addr_i[1:0] != 2'b00);
            default: w_misaligned = 1'b0;
        endcase
        if (w_is_store) begin
            case (bus.funct3_i[1:0])
                2'b00: begin
                    w_be    = 4'b0001 << bus.addr_i[1:0];
                    w_wdata = {4{bus.wdata_i[7:0]}};
                end
                2'b01: begin
                    w_be    = 4'b0011 << bus.addr_i[1:0];
                    w_wdata = {2{bus.wdata_i[15:0]}};
                end
                default: begin
                    w_be    = 4'b1111;
                    w_wdata = bus.wdata_i;
                end
            endcase
        end
    end

    // Select and extend the returning lane using the oldest FIFO entry
    always_comb begin
        w_head = r_meta[r_rd_ptr];
        w_byte = bus.data_rdata_i[{w_head.off, 3'b000} +: 8];
        w_half = bus.data_rdata_i[{w_head.off[1], 4'b0000} +: 16];
        case (w_head.funct3)
            3'b000:  w_load_data = {{24{w_byte[7]}}, w_byte};
            3'b001:  w_load_data = {{16{w_half[15]}}, w_half};
            3'b100:  w_load_data = {24'h000000, w_byte};
            3'b101:  w_load_data = {16'h0000, w_half};
            default: w_load_data = bus.data_rdata_i;
        endcase
    end

    // Hold register: capture a legal operation, release it when granted
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_hold_valid <= 1'b0;
            r_hold_addr  <= '0;
            r_hold_we    <= 1'b0;
            r_hold_be    <= '0;
            r_hold_wdata <= '0;
        end else if (w_issue) begin
            r_hold_valid <= 1'b1;
            r_hold_addr  <= {bus.addr_i[ADDR_W-1:2], 2'b00};
            r_hold_we    <= w_is_store;
            r_hold_be    <= w_be;
            r_hold_wdata <= w_wdata;
        end else if (r_hold_valid && bus.data_gnt_i) begin
            r_hold_valid <= 1'b0;
        end
    end

    // Outstanding counter and metadata FIFO move together: push on issue, pop on response
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt    <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_meta[i] <= '0;
            end
        end else begin
            if (w_issue && !w_pop) begin
                r_cnt <= r_cnt + 1'b1;
            end else if (!w_issue && w_pop) begin
                r_cnt <= r_cnt - 1'b1;
            end
            if (w_issue) begin
                r_meta[r_wr_ptr] <= '{is_load: w_is_load, rd: bus.rd_i,
                                      funct3: bus.funct3_i, off: bus.addr_i[1:0]};
                r_wr_ptr         <= ptr_inc(r_wr_ptr);
            end
            if (w_pop) begin
                r_rd_ptr <= ptr_inc(r_rd_ptr);
            end
        end
    end

    // Writeback: one-cycle pulse for load responses, stores retire silently
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wb_valid <= 1'b0;
            r_wb_rd    <= '0;
            r_wb_data  <= '0;
        end else begin
            r_wb_valid <= w_pop && w_head.is_load;
            if (w_pop && w_head.is_load) begin
                r_wb_rd   <= w_head.rd;
                r_wb_data <= w_load_data;
            end
        end
    end

    // Exceptions: illegal wins over misaligned; faulting address is held
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_illegal    <= 1'b0;
            r_misaligned <= 1'b0;
            r_exc_addr   <= '0;
        end else begin
            r_illegal    <= w_accept && !w_legal;
            r_misaligned <= w_accept && w_legal && w_misaligned;
            if (w_accept && (!w_legal || w_misaligned)) begin
                r_exc_addr <= bus.addr_i;
            end
        end
    end

    assign bus.req_ready_o  = w_ready;
    assign bus.data_req_o   = r_hold_valid;
    assign bus.data_addr_o  = r_hold_addr;
    assign bus.data_we_o    = r_hold_we;
    assign bus.data_be_o    = r_hold_be;
    assign bus.data_wdata_o = r_hold_wdata;
    assign bus.wb_valid_o   = r_wb_valid;
    assign bus.wb_rd_o      = r_wb_rd;
    assign bus.wb_data_o    = r_wb_data;
    assign bus.misaligned_o = r_misaligned;
    assign bus.illegal_o    = r_illegal;
    assign bus.exc_addr_o   = r_exc_addr;
    assign bus.busy_o       = r_hold_valid || (r_cnt != '0);

endmodule
`default_nettype wire

// File: tb/tb_lsu_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_lsu_pipe
// Description : Self-checking bench for lsu_pipe. Directed scenarios followed
//               by randomized traffic, all checked against a queue-based
//               reference model of the unit's externally visible behaviour.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lsu_pipe;

    localparam int         DEPTH = 2;
    localparam logic [6:0] OP_LD = 7'b0000011;
    localparam logic [6:0] OP_ST = 7'b0100011;

    typedef struct {
        logic        is_load;
        logic [4:0]  rd;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wd;
    } op_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    lsu_pipe_if #(.ADDR_W(32)) b ();

    lsu_pipe #(.ADDR_W(32), .DEPTH(DEPTH)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b)
    );

    int          n_vec = 0;
    int          n_err = 0;
    op_t         hold_q[$];
    op_t         out_q[$];
    logic [31:0] m_exc = '0;
    logic        obs_ready;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int nbytes(input logic [2:0] f3);
        case (f3[1:0])
            2'b00:   return 1;
            2'b01:   return 2;
            default: return 4;
        endcase
    endfunction

    // 0 = good, 1 = illegal, 2 = misaligned
    function automatic int classify(input logic [6:0] opc, input logic [2:0] f3, input logic [31:0] a);
        bit ok_ld;
        bit ok_st;
        ok_ld = (opc == OP_LD) && (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        ok_st = (opc == OP_ST) && (f3 inside {3'd0, 3'd1, 3'd2});
        if (!ok_ld && !ok_st) return 1;
        if ((a % nbytes(f3)) != 0) return 2;
        return 0;
    endfunction

    function automatic logic [3:0] exp_be(input op_t o);
        int sh;
        if (o.is_load) return 4'hF;
        sh = int'(o.addr[1:0]);
        return 4'(((1 << nbytes(o.f3)) - 1) << sh);
    endfunction

    function automatic logic [31:0] exp_wd(input op_t o);
        case (nbytes(o.f3))
            1:       return (o.wd & 32'h000000FF) * 32'h01010101;
            2:       return (o.wd & 32'h0000FFFF) * 32'h00010001;
            default: return o.wd;
        endcase
    endfunction

    function automatic logic [31:0] extend(input op_t o, input logic [31:0] rdat);
        longint v;
        longint span;
        int     n;
        n = nbytes(o.f3);
        if (n == 4) return rdat;
        span = longint'(1) << (8 * n);
        v    = longint'(rdat >> (8 * int'(o.addr[1:0]))) % span;
        if (!o.f3[2] && (v >= span / 2)) v = v - span;
        return 32'(v);
    endfunction

    // One clock cycle: drive inputs, check bus side against the model, advance, check results
    task automatic cycle(input logic v, input logic [6:0] opc, input logic [2:0] f3,
                         input logic [4:0] rd, input logic [31:0] addr, input logic [31:0] wd,
                         input logic g, input logic rv, input logic [31:0] rdat);
        op_t         o;
        op_t         h;
        int          kind;
        logic        e_rdy;
        logic        e_wbv;
        logic        e_mis;
        logic        e_ill;
        logic [4:0]  e_rd;
        logic [31:0] e_wbd;
        b.req_valid_i   = v;
        b.opcode_i      = opc;
        b.funct3_i      = f3;
        b.rd_i          = rd;
        b.addr_i        = addr;
        b.wdata_i       = wd;
        b.data_gnt_i    = g;
        b.data_rvalid_i = rv;
        b.data_rdata_i  = rdat;
        #1;
        obs_ready = b.req_ready_o;
        e_rdy = ((hold_q.size() + out_q.size()) < DEPTH) && ((hold_q.size() == 0) || g);
        check("ready", 32'(b.req_ready_o), 32'(e_rdy));
        check("data_req", 32'(b.data_req_o), 32'(hold_q.size() != 0));
        if (hold_q.size() != 0) begin
            h = hold_q[0];
            check("data_addr", b.data_addr_o, {h.addr[31:2], 2'b00});
            check("data_we", 32'(b.data_we_o), 32'(!h.is_load));
            check("data_be", 32'(b.data_be_o), 32'(exp_be(h)));
            if (!h.is_load) check("data_wdata", b.data_wdata_o, exp_wd(h));
        end
        e_wbv = 1'b0;
        e_mis = 1'b0;
        e_ill = 1'b0;
        e_rd  = '0;
        e_wbd = '0;
        if (rv && (out_q.size() != 0)) begin
            o = out_q.pop_front();
            if (o.is_load) begin
                e_wbv = 1'b1;
                e_rd  = o.rd;
                e_wbd = extend(o, rdat);
            end
        end
        if ((hold_q.size() != 0) && g) out_q.push_back(hold_q.pop_front());
        if (v && e_rdy) begin
            kind = classify(opc, f3, addr);
            if (kind == 1) begin
                e_ill = 1'b1;
                m_exc = addr;
            end else if (kind == 2) begin
                e_mis = 1'b1;
                m_exc = addr;
            end else begin
                o.is_load = (opc == OP_LD);
                o.rd      = rd;
                o.f3      = f3;
                o.addr    = addr;
                o.wd      = wd;
                hold_q.push_back(o);
            end
        end
        @(posedge clk);
        #1;
        check("wb_valid", 32'(b.wb_valid_o), 32'(e_wbv));
        if (e_wbv) begin
            check("wb_rd", 32'(b.wb_rd_o), 32'(e_rd));
            check("wb_data", b.wb_data_o, e_wbd);
        end
        check("misaligned", 32'(b.misaligned_o), 32'(e_mis));
        check("illegal", 32'(b.illegal_o), 32'(e_ill));
        check("exc_addr", b.exc_addr_o, m_exc);
        check("busy", 32'(b.busy_o), 32'((hold_q.size() + out_q.size()) != 0));
    endtask

    task automatic op(input logic [6:0] opc, input logic [2:0] f3, input logic [4:0] rd,
                      input logic [31:0] addr, input logic [31:0] wd);
        cycle(1'b1, opc, f3, rd, addr, wd, 1'b1, 1'b0, 32'h0);
    endtask

    task automatic idle(input logic g, input logic rv, input logic [31:0] rdat);
        cycle(1'b0, 7'h0, 3'h0, 5'h0, 32'h0, 32'h0, g, rv, rdat);
    endtask

    // Issue a load, grant it, return rdata; writeback is visible on return
    task automatic ld(input logic [2:0] f3, input logic [4:0] rd, input logic [31:0] addr,
                      input logic [31:0] rdat);
        op(OP_LD, f3, rd, addr, 32'h0);
        idle(1'b1, 1'b0, 32'h0);
        idle(1'b0, 1'b1, rdat);
    endtask

    task automatic do_reset();
        rst_n           = 1'b0;
        b.req_valid_i   = 1'b0;
        b.data_gnt_i    = 1'b0;
        b.data_rvalid_i = 1'b0;
        b.data_rdata_i  = '0;
        @(posedge clk);
        #1;
        check("rst data_req", 32'(b.data_req_o), 32'h0);
        check("rst data_be", 32'(b.data_be_o), 32'h0);
        check("rst wb_valid", 32'(b.wb_valid_o), 32'h0);
        check("rst wb_data", b.wb_data_o, 32'h0);
        check("rst exc_addr", b.exc_addr_o, 32'h0);
        check("rst busy", 32'(b.busy_o), 32'h0);
        check("rst misaligned", 32'(b.misaligned_o), 32'h0);
        check("rst illegal", 32'(b.illegal_o), 32'h0);
        rst_n = 1'b1;
        hold_q.delete();
        out_q.delete();
        m_exc = '0;
    endtask

    logic [2:0] ld_f3 [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
    logic [2:0] lb_f3 [7] = '{3'd0, 3'd0, 3'd0, 3'd0, 3'd4, 3'd1, 3'd5};
    logic [1:0] lb_off [7] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd3, 2'd2, 2'd2};
    logic [31:0] lb_exp [7] = '{32'h00000001, 32'h0000007F, 32'hFFFFFFFF, 32'hFFFFFF80,
                                32'h00000080, 32'hFFFF80FF, 32'h000080FF};

    initial begin
        b.req_valid_i   = 1'b0;
        b.opcode_i      = '0;
        b.funct3_i      = '0;
        b.rd_i          = '0;
        b.addr_i        = '0;
        b.wdata_i       = '0;
        b.data_gnt_i    = 1'b0;
        b.data_rvalid_i = 1'b0;
        b.data_rdata_i  = '0;
        @(posedge clk);
        #1;
        do_reset();

        // Aligned store then load
        op(OP_ST, 3'd2, 5'd0, 32'h1000, 32'hDEADBEEF);
        check("sw req", 32'(b.data_req_o), 32'h1);
        check("sw be", 32'(b.data_be_o), 32'hF);
        check("sw wdata", b.data_wdata_o, 32'hDEADBEEF);
        idle(1'b1, 1'b0, 32'h0);
        check("sw req drop", 32'(b.data_req_o), 32'h0);
        idle(1'b0, 1'b1, 32'h0);
        ld(3'd2, 5'd5, 32'h1000, 32'hDEADBEEF);
        check("lw wb_valid", 32'(b.wb_valid_o), 32'h1);
        check("lw rd", 32'(b.wb_rd_o), 32'd5);
        check("lw data", b.wb_data_o, 32'hDEADBEEF);
        idle(1'b0, 1'b0, 32'h0);

        // Sub-word extension
        for (int i = 0; i < 7; i++) begin
            ld(lb_f3[i], 5'(i + 1), {30'h400, lb_off[i]}, 32'h80FF7F01);
            check("ext data", b.wb_data_o, lb_exp[i]);
        end

        // Store lanes
        op(OP_ST, 3'd0, 5'd0, 32'h1003, 32'h000000AB);
        check("sb be", 32'(b.data_be_o), 32'h8);
        check("sb wdata", b.data_wdata_o, 32'hABABABAB);
        idle(1'b1, 1'b0, 32'h0);
        idle(1'b0, 1'b1, 32'h0);
        op(OP_ST, 3'd1, 5'd0, 32'h1002, 32'h00001234);
        check("sh be", 32'(b.data_be_o), 32'hC);
        check("sh wdata", b.data_wdata_o, 32'h12341234);
        idle(1'b1, 1'b0, 32'h0);
        idle(1'b0, 1'b1, 32'h0);

        // Faults
        op(OP_LD, 3'd2, 5'd3, 32'h1002, 32'h0);
        check("mis pulse", 32'(b.misaligned_o), 32'h1);
        check("mis addr", b.exc_addr_o, 32'h1002);
        check("mis no req", 32'(b.data_req_o), 32'h0);
        idle(1'b0, 1'b0, 32'h0);
        op(OP_LD, 3'd3, 5'd3, 32'h2000, 32'h0);
        check("ill pulse", 32'(b.illegal_o), 32'h1);
        idle(1'b0, 1'b0, 32'h0);

        // Back-pressure: grant low for three cycles
        op(OP_LD, 3'd2, 5'd7, 32'h2000, 32'h0);
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, OP_LD, 3'd2, 5'd8, 32'h3000, 32'h0, 1'b0, 1'b0, 32'h0);
            check("bp ready", 32'(obs_ready), 32'h0);
            check("bp addr", b.data_addr_o, 32'h2000);
            check("bp be", 32'(b.data_be_o), 32'hF);
            check("bp we", 32'(b.data_we_o), 32'h0);
        end
        idle(1'b1, 1'b0, 32'h0);
        idle(1'b0, 1'b1, 32'h12345678);
        check("bp wb rd", 32'(b.wb_rd_o), 32'd7);

        // Depth limit and in-order responses
        cycle(1'b1, OP_LD, 3'd2, 5'd1, 32'h100, 32'h0, 1'b1, 1'b0, 32'h0);
        cycle(1'b1, OP_LD, 3'd2, 5'd2, 32'h104, 32'h0, 1'b1, 1'b0, 32'h0);
        check("depth ready2", 32'(obs_ready), 32'h1);
        cycle(1'b1, OP_LD, 3'd2, 5'd3, 32'h108, 32'h0, 1'b1, 1'b0, 32'h0);
        check("depth stall", 32'(obs_ready), 32'h0);
        cycle(1'b1, OP_LD, 3'd2, 5'd3, 32'h108, 32'h0, 1'b1, 1'b1, 32'h11);
        check("full same-cycle", 32'(obs_ready), 32'h0);
        check("order rd1", 32'(b.wb_rd_o), 32'd1);
        cycle(1'b1, OP_LD, 3'd2, 5'd3, 32'h108, 32'h0, 1'b1, 1'b0, 32'h0);
        check("depth resume", 32'(obs_ready), 32'h1);
        idle(1'b1, 1'b1, 32'h22);
        check("order rd2", 32'(b.wb_rd_o), 32'd2);
        idle(1'b0, 1'b1, 32'h33);
        check("order rd3", 32'(b.wb_rd_o), 32'd3);

        // Reset with two loads outstanding, then a stray response
        cycle(1'b1, OP_LD, 3'd2, 5'd9, 32'h200, 32'h0, 1'b1, 1'b0, 32'h0);
        cycle(1'b1, OP_LD, 3'd2, 5'd10, 32'h204, 32'h0, 1'b1, 1'b0, 32'h0);
        idle(1'b1, 1'b0, 32'h0);
        do_reset();
        idle(1'b0, 1'b1, 32'h55);
        check("stray wb", 32'(b.wb_valid_o), 32'h0);
        check("stray busy", 32'(b.busy_o), 32'h0);

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            int          r;
            logic [6:0]  opc;
            logic [2:0]  f3;
            logic [31:0] a;
            r = int'($urandom_range(0, 99));
            if (r < 45)      opc = OP_LD;
            else if (r < 90) opc = OP_ST;
            else             opc = 7'($urandom);
            if ($urandom_range(0, 9) < 8) begin
                if (opc == OP_ST) f3 = 3'($urandom_range(0, 2));
                else              f3 = ld_f3[$urandom_range(0, 4)];
            end else begin
                f3 = 3'($urandom);
            end
            a = $urandom;
            if ($urandom_range(0, 1) == 1) a = a & ~(32'(nbytes(f3)) - 32'd1);
            cycle(1'($urandom_range(0, 3) != 0), opc, f3, 5'($urandom), a, $urandom,
                  1'($urandom_range(0, 3) != 0),
                  (out_q.size() != 0) && ($urandom_range(0, 2) != 0), $urandom);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
